// File: rtl/gl_cmd_loader.sv
// -----------------------------------------------------------------------------
// gl_cmd_loader
//
// Writer side of the instruction BRAM that the fetch stage drains. Host
// command words arrive on a valid/ready stream. Each header's opcode byte
// [7:0] sets how many operands follow it. Every accepted word is written to
// the next sequential BRAM address, starting at 0. Fetch is held off until a
// complete program, closed by a JMP header, is resident.
//
// Ports
//   clk           clock
//   reset         synchronous, active-high reset
//   in_data       host command word
//   in_valid      in_data valid
//   in_ready      word accepted when in_valid && in_ready (combinational)
//   load_start    1-cycle pulse: discard the program and restart at address 0
//   bram_we       BRAM write enable (registered)
//   bram_addr     BRAM write address (registered)
//   bram_wdata    BRAM write data (registered)
//   fetch_hold    stall to fetch; low only while a complete program is held
//   frame_done    1-cycle pulse, issued with the bram_we of the closing JMP
//   word_count    words written in the current program
//   cmd_count     command headers written in the current program
//   overflow_err  sticky: a command was rejected for lack of space
// -----------------------------------------------------------------------------
module gl_cmd_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              load_start,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_wdata,
    output logic              fetch_hold,
    output logic              frame_done,
    output logic [ADDR_W:0]   word_count,
    output logic [CNT_W-1:0]  cmd_count,
    output logic              overflow_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    // Wide enough to hold wr_ptr + the longest command (17) without wrapping.
    localparam int SUM_W = ADDR_W + 6;
    localparam logic [7:0] OP_JMP = 8'h06;

    typedef enum logic [1:0] {
        S_HDR,
        S_OPS,
        S_DONE,
        S_ERR
    } state_t;

    // Command length in words, header included.
    function automatic logic [4:0] f_cmd_len(input logic [7:0] op);
        case (op)
            8'h03, 8'h04:                       f_cmd_len = 5'd4;
            8'h11, 8'h13, 8'h16, 8'h17,
            8'h18, 8'h1A, 8'h1B:                f_cmd_len = 5'd17;
            8'h19:                              f_cmd_len = 5'd5;
            // NOTE: the default arm makes the decode total, so no latch is inferred.
            default:                            f_cmd_len = 5'd1;
        endcase
    endfunction

    state_t              r_state;
    logic [ADDR_W:0]     r_wr_ptr;      // also the word count; reaches DEPTH only after a JMP at DEPTH-1
    logic [4:0]          r_rem;         // operands still owed by the current command
    logic [CNT_W-1:0]    r_cmd_count;
    logic                r_ovf;
    logic                r_fetch_hold;
    logic                r_frame_done;
    logic                r_bram_we;
    logic [ADDR_W-1:0]   r_bram_addr;
    logic [31:0]         r_bram_wdata;

    logic                w_ready;
    logic                w_accept;
    logic                w_is_jmp;
    logic [4:0]          w_len;
    logic [SUM_W-1:0]    w_need;
    logic                w_fits;
    logic                w_write;

    // ERR keeps accepting so a broken host stream drains instead of stalling.
    assign w_ready  = (r_state != S_DONE) && !load_start;
    assign w_accept = in_valid && w_ready;
    assign w_is_jmp = (in_data[7:0] == OP_JMP);
    assign w_len    = f_cmd_len(in_data[7:0]);

    // The top slot is always kept free so the closing JMP is guaranteed room.
    assign w_need   = SUM_W'(r_wr_ptr) + SUM_W'(w_len);
    assign w_fits   = (w_need <= SUM_W'(DEPTH - 1));

    // Operands are written blindly; headers only if they are a JMP or fit.
    assign w_write  = w_accept &&
                      ((r_state == S_OPS) ||
                       ((r_state == S_HDR) && (w_is_jmp || w_fits)));

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: all sequential state uses non-blocking assignments so that every register samples pre-edge values.
            r_state      <= S_HDR;
            r_wr_ptr     <= '0;
            r_rem        <= '0;
            r_cmd_count  <= '0;
            r_ovf        <= 1'b0;
            r_fetch_hold <= 1'b1;
            r_frame_done <= 1'b0;
            r_bram_we    <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_wdata <= '0;
        end else begin
            r_bram_we    <= 1'b0;
            r_frame_done <= 1'b0;

            // Registered write port: the word accepted this cycle appears on the BRAM next cycle.
            if (w_write) begin
                r_bram_we    <= 1'b1;
                r_bram_addr  <= r_wr_ptr[ADDR_W-1:0];
                r_bram_wdata <= in_data;
                r_wr_ptr     <= r_wr_ptr + (ADDR_W+1)'(1);
            end

            if (load_start) begin
                // in_ready is low here, so no new write competes with the restart.
                r_state      <= S_HDR;
                r_wr_ptr     <= '0;
                r_rem        <= '0;
                r_cmd_count  <= '0;
                r_ovf        <= 1'b0;
                r_fetch_hold <= 1'b1;
            end else if (w_accept) begin
                case (r_state)
                    S_HDR: begin
                        if (w_is_jmp) begin
                            r_cmd_count  <= r_cmd_count + CNT_W'(1);
                            r_state      <= S_DONE;
                            r_frame_done <= 1'b1;
                            r_fetch_hold <= 1'b0;
                        end else if (w_fits) begin
                            r_cmd_count  <= r_cmd_count + CNT_W'(1);
                            r_rem        <= w_len - 5'd1;
                            r_state      <= (w_len > 5'd1) ? S_OPS : S_HDR;
                        end else begin
                            r_ovf        <= 1'b1;
                            r_state      <= S_ERR;
                        end
                    end
                    S_OPS: begin
                        r_rem <= r_rem - 5'd1;
                        if (r_rem == 5'd1) begin
                            r_state <= S_HDR;
                        end
                    end
                    // ERR drops everything; DONE never accepts.
                    default: begin
                    end
                endcase
            end
        end
    end

    assign in_ready     = w_ready;
    assign bram_we      = r_bram_we;
    assign bram_addr    = r_bram_addr;
    assign bram_wdata   = r_bram_wdata;
    assign fetch_hold   = r_fetch_hold;
    assign frame_done   = r_frame_done;
    assign word_count   = r_wr_ptr;
    assign cmd_count    = r_cmd_count;
    assign overflow_err = r_ovf;

endmodule

// File: tb/tb_gl_cmd_loader.sv
// -----------------------------------------------------------------------------
// tb_gl_cmd_loader
//
// Two loaders share one input stream: a full-size one (ADDR_W=10) and a
// small one (ADDR_W=4) that exercises the space limit. A per-instance
// reference model tracks each program from the command-framing rules and
// predicts every registered output one cycle after each input step.
// -----------------------------------------------------------------------------
module tb_gl_cmd_loader;

    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        load_start = 1'b0;

    // Full-size instance
    logic        b_in_ready, b_bram_we, b_fetch_hold, b_frame_done, b_overflow_err;
    logic [9:0]  b_bram_addr;
    logic [31:0] b_bram_wdata;
    logic [10:0] b_word_count;
    logic [CNT_W-1:0] b_cmd_count;

    // Small instance
    logic        s_in_ready, s_bram_we, s_fetch_hold, s_frame_done, s_overflow_err;
    logic [3:0]  s_bram_addr;
    logic [31:0] s_bram_wdata;
    logic [4:0]  s_word_count;
    logic [CNT_W-1:0] s_cmd_count;

    always #5 clk = ~clk;

    gl_cmd_loader #(.ADDR_W(10), .CNT_W(CNT_W)) u_big (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .load_start(load_start), .bram_we(b_bram_we),
        .bram_addr(b_bram_addr), .bram_wdata(b_bram_wdata),
        .fetch_hold(b_fetch_hold), .frame_done(b_frame_done),
        .word_count(b_word_count), .cmd_count(b_cmd_count),
        .overflow_err(b_overflow_err)
    );

    gl_cmd_loader #(.ADDR_W(4), .CNT_W(CNT_W)) u_small (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(s_in_ready), .load_start(load_start), .bram_we(s_bram_we),
        .bram_addr(s_bram_addr), .bram_wdata(s_bram_wdata),
        .fetch_hold(s_fetch_hold), .frame_done(s_frame_done),
        .word_count(s_word_count), .cmd_count(s_cmd_count),
        .overflow_err(s_overflow_err)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (index 0 = big, 1 = small) -------------
    int          depth  [2] = '{1024, 16};
    bit          m_init = 1'b0;
    bit          m_done [2] = '{0, 0};   // program closed by JMP
    bit          m_err  [2] = '{0, 0};   // command rejected, dropping words
    int          m_rem  [2] = '{0, 0};   // operands still owed
    int          m_wp   [2] = '{0, 0};
    int          m_cc   [2] = '{0, 0};
    bit          m_ovf  [2] = '{0, 0};
    bit          m_we   [2] = '{0, 0};
    bit          m_fd   [2] = '{0, 0};
    bit          m_chk  [2] = '{0, 0};   // bus value is defined this cycle
    int          m_addr [2] = '{0, 0};
    logic [31:0] m_wd   [2];

    function automatic int cmd_len(input logic [7:0] op);
        case (op)
            8'h03, 8'h04: return 4;
            8'h11, 8'h13, 8'h16, 8'h17, 8'h18, 8'h1A, 8'h1B: return 17;
            8'h19: return 5;
            default: return 1;
        endcase
    endfunction

    task automatic model_write(input int k, input logic [31:0] d);
        m_we[k]   = 1'b1;
        m_chk[k]  = 1'b1;
        m_addr[k] = m_wp[k];
        m_wd[k]   = d;
        m_wp[k]   = m_wp[k] + 1;
    endtask

    task automatic model_step(input int k, input logic v, input logic [31:0] d,
                              input logic ls, input logic rst, input logic rdy);
        int len;
        m_we[k]  = 1'b0;
        m_fd[k]  = 1'b0;
        m_chk[k] = 1'b0;
        if (rst || ls) begin
            m_done[k] = 1'b0; m_err[k] = 1'b0; m_rem[k] = 0;
            m_wp[k] = 0; m_cc[k] = 0; m_ovf[k] = 1'b0;
            if (rst) begin
                m_addr[k] = 0; m_wd[k] = '0; m_chk[k] = 1'b1;
            end
        end else if (v && rdy && !m_err[k]) begin
            if (m_rem[k] > 0) begin
                model_write(k, d);
                m_rem[k] = m_rem[k] - 1;
            end else if (d[7:0] == 8'h06) begin
                model_write(k, d);
                m_cc[k] = m_cc[k] + 1;
                m_done[k] = 1'b1;
                m_fd[k] = 1'b1;
            end else begin
                len = cmd_len(d[7:0]);
                if (m_wp[k] + len <= depth[k] - 1) begin
                    model_write(k, d);
                    m_cc[k]  = m_cc[k] + 1;
                    m_rem[k] = len - 1;
                end else begin
                    m_ovf[k] = 1'b1;
                    m_err[k] = 1'b1;
                end
            end
        end
    endtask

    // ---------------- checking ----------------------------------------------
    task automatic check(input string tag, input int k,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic check_outputs(input int k);
        logic [31:0] we, addr, wd, fh, fd, wc, cc, ov;
        if (k == 0) begin
            we = 32'(b_bram_we); addr = 32'(b_bram_addr); wd = b_bram_wdata;
            fh = 32'(b_fetch_hold); fd = 32'(b_frame_done);
            wc = 32'(b_word_count); cc = 32'(b_cmd_count); ov = 32'(b_overflow_err);
        end else begin
            we = 32'(s_bram_we); addr = 32'(s_bram_addr); wd = s_bram_wdata;
            fh = 32'(s_fetch_hold); fd = 32'(s_frame_done);
            wc = 32'(s_word_count); cc = 32'(s_cmd_count); ov = 32'(s_overflow_err);
        end
        check("bram_we", k, we, 32'(m_we[k]));
        if (m_chk[k]) begin
            check("bram_addr", k, addr, 32'(m_addr[k]));
            check("bram_wdata", k, wd, m_wd[k]);
        end
        check("frame_done", k, fd, 32'(m_fd[k]));
        check("fetch_hold", k, fh, 32'(!m_done[k]));
        check("word_count", k, wc, 32'(m_wp[k]));
        check("cmd_count", k, cc, 32'(m_cc[k]));
        check("overflow_err", k, ov, 32'(m_ovf[k]));
    endtask

    // One clock: drive at the falling edge, check in_ready before the rising
    // edge, advance the model at the rising edge, check outputs at the next
    // falling edge.
    task automatic step(input logic v, input logic [31:0] d,
                        input logic ls, input logic rst);
        logic rdy_exp [2];
        in_valid = v; in_data = d; load_start = ls; reset = rst;
        #1;
        for (int k = 0; k < 2; k++) begin
            rdy_exp[k] = !m_done[k] && !ls;
            if (m_init)
                check("in_ready", k, (k == 0) ? 32'(b_in_ready) : 32'(s_in_ready),
                      32'(rdy_exp[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, v, d, ls, rst, rdy_exp[k]);
        if (rst) m_init = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_outputs(k);
    endtask

    task automatic send(input logic [31:0] w);
        step(1'b1, w, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, $urandom, 1'b0, 1'b0);
    endtask

    task automatic restart();
        step(1'b0, $urandom, 1'b1, 1'b0);
    endtask

    // Randomised send: optional idle gap, and a rare load_start collision.
    task automatic send_rand(input logic [31:0] w);
        while ($urandom_range(0, 3) == 0) idle();
        step(1'b1, w, ($urandom_range(0, 59) == 0), 1'b0);
    endtask

    logic [7:0] ops [14] = '{8'h03, 8'h04, 8'h11, 8'h13, 8'h16, 8'h17, 8'h18,
                             8'h1A, 8'h1B, 8'h19, 8'h00, 8'h07, 8'hFF, 8'h20};

    initial begin
        logic [31:0] w;
        int ncmd, len;

        // Reset state
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        idle();

        // 1: VERTEX + 3 operands, then JMP
        send(32'h0000_0003);
        for (int i = 0; i < 3; i++) send($urandom);
        send(32'h0000_0006);
        idle(); idle();

        // 2: LOADMATRIX with an operand that looks like JMP, valid every other cycle
        restart();
        send(32'h8000_1013); idle();
        for (int i = 0; i < 16; i++) begin
            send((i == 5) ? 32'h0000_0006 : $urandom);
            idle();
        end
        idle();

        // 3: fill the small loader to wr_ptr=11, then a VIEWPORT that cannot fit
        restart();
        send(32'h0000_0003); for (int i = 0; i < 3; i++) send($urandom);
        send(32'h0000_0003); for (int i = 0; i < 3; i++) send($urandom);
        for (int i = 0; i < 3; i++) send(32'h0000_0000);
        send(32'h0000_0019);
        for (int i = 0; i < 8; i++) send($urandom);
        idle();

        // 4: load_start while operand 2 of a COLOR is presented
        restart();
        send(32'h0000_0004);
        send($urandom);
        step(1'b1, $urandom, 1'b1, 1'b0);
        send(32'h0000_0003); for (int i = 0; i < 3; i++) send($urandom);
        send(32'hABCD_0006);
        idle();

        // 5: load_start in DONE, then a new program
        restart();
        send(32'h0000_0000);
        send(32'h0000_0004); for (int i = 0; i < 3; i++) send($urandom);
        send(32'h0000_0006);
        idle();

        // 6: reset together with load_start and valid mid-command
        restart();
        send(32'h0000_0004);
        send($urandom);
        step(1'b1, $urandom, 1'b1, 1'b1);
        idle();

        // Random programs
        for (int r = 0; r < 8; r++) begin
            restart();
            ncmd = $urandom_range(3, 12);
            for (int c = 0; c < ncmd; c++) begin
                w = $urandom;
                w[7:0] = ops[$urandom_range(0, 13)];
                len = cmd_len(w[7:0]);
                send_rand(w);
                for (int i = 1; i < len; i++) send_rand($urandom);
            end
            w = $urandom;
            w[7:0] = 8'h06;
            send_rand(w);
            for (int i = 0; i < 3; i++) send($urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
